// File: rtl/nco_sweep_pkg.sv
// nco_sweep_pkg
// Shared encodings for the NCO phase-increment sweep controller:
//   sweep_mode_e  - sweep mode field encoding (reserved value behaves as single)
//   sweep_state_e - controller FSM states
package nco_sweep_pkg;

  typedef enum logic [1:0] {
    SWEEP_SINGLE = 2'd0,
    SWEEP_REPEAT = 2'd1,
    SWEEP_TRI    = 2'd2,
    SWEEP_RSVD   = 2'd3
  } sweep_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sweep_state_e;

endpackage

// File: rtl/nco_sweep_next.sv
// nco_sweep_next
// Combinational step-and-clamp for the sweep controller. Produces the next
// phase increment one step from cur toward target, never passing target and
// never wrapping modulo 2^APR.
// Ports:
//   cur       in  APR  current increment
//   target    in  APR  increment being approached
//   step      in  APR  step magnitude
//   dir_up    in  1    1: step upward, 0: step downward
//   nxt       out APR  next increment (clamped to target)
//   at_target out 1    cur already equals target
module nco_sweep_next
  import nco_sweep_pkg::*;
#(
  parameter int APR = 20
) (
  input  logic [APR-1:0] cur,
  input  logic [APR-1:0] target,
  input  logic [APR-1:0] step,
  input  logic           dir_up,
  output logic [APR-1:0] nxt,
  output logic           at_target
);

  // One extra bit exposes carry-out (up) and borrow (down) so a step that
  // would wrap is seen as passing the target and gets clamped.
  logic [APR:0] sum_s;
  logic [APR:0] diff_s;

  // Step toward the target and clamp on overshoot
  always_comb begin
    sum_s     = {1'b0, cur} + {1'b0, step};
    diff_s    = {1'b0, cur} - {1'b0, step};
    at_target = (cur == target);
    if (dir_up) begin
      if (sum_s > {1'b0, target}) begin
        nxt = target;
      end else begin
        nxt = sum_s[APR-1:0];
      end
    end else begin
      if (diff_s[APR] || (diff_s[APR-1:0] < target)) begin
        nxt = target;
      end else begin
        nxt = diff_s[APR-1:0];
      end
    end
  end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl
// Phase-increment sequencer feeding the NCO phi_inc_i input. Steps the
// increment from start_inc toward stop_inc in step_inc steps, holding each
// value for dwell+1 enabled cycles. Single, repeating and triangle sweeps.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   clken            clock enable shared with the NCO; low freezes everything
//   start, abort     control pulses (abort has priority)
//   mode             0 single, 1 repeat, 2 triangle, 3 behaves as single
//   start_inc, stop_inc, step_inc, dwell   sweep configuration, latched on start
//   phi_inc_o        registered increment to the NCO
//   busy             sweep in progress
//   step_strobe      one-cycle pulse on each phi_inc_o update
//   sweep_done       one-cycle pulse at each end of sweep
module nco_sweep_ctrl
  import nco_sweep_pkg::*;
#(
  parameter int APR = 20,
  parameter int DW  = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clken,
  input  logic           start,
  input  logic           abort,
  input  logic [1:0]     mode,
  input  logic [APR-1:0] start_inc,
  input  logic [APR-1:0] stop_inc,
  input  logic [APR-1:0] step_inc,
  input  logic [DW-1:0]  dwell,
  output logic [APR-1:0] phi_inc_o,
  output logic           busy,
  output logic           step_strobe,
  output logic           sweep_done
);

  localparam logic [DW-1:0] CNT_ZERO = {DW{1'b0}};
  localparam logic [DW-1:0] CNT_ONE  = {{(DW-1){1'b0}}, 1'b1};

  sweep_state_e   state_r,  state_s;
  logic [APR-1:0] phi_r,    phi_s;
  logic [DW-1:0]  cnt_r,    cnt_s;
  sweep_mode_e    mode_r,   mode_s;
  logic [APR-1:0] origin_r, origin_s;   // value the sweep leaves from
  logic [APR-1:0] target_r, target_s;   // value the sweep heads for
  logic [APR-1:0] step_r,   step_s;
  logic [DW-1:0]  dwell_r,  dwell_s;
  logic           dir_up_r, dir_up_s;
  logic           busy_r,   busy_s;
  logic           strobe_r, strobe_s;
  logic           done_r,   done_s;

  logic [APR-1:0] nxt_fwd_s;
  logic [APR-1:0] nxt_rev_s;
  logic           at_target_s;
  logic           at_origin_s;

  // Normal step toward the current target.
  nco_sweep_next #(.APR(APR)) u_next_fwd (
    .cur       (phi_r),
    .target    (target_r),
    .step      (step_r),
    .dir_up    (dir_up_r),
    .nxt       (nxt_fwd_s),
    .at_target (at_target_s)
  );

  // Triangle turnaround: first step back toward the origin, computed in the
  // same cycle the end of the leg is reached.
  nco_sweep_next #(.APR(APR)) u_next_rev (
    .cur       (phi_r),
    .target    (origin_r),
    .step      (step_r),
    .dir_up    (~dir_up_r),
    .nxt       (nxt_rev_s),
    .at_target (at_origin_s)
  );

  // Next-state, datapath and strobe decode
  always_comb begin
    state_s  = state_r;
    phi_s    = phi_r;
    cnt_s    = cnt_r;
    mode_s   = mode_r;
    origin_s = origin_r;
    target_s = target_r;
    step_s   = step_r;
    dwell_s  = dwell_r;
    dir_up_s = dir_up_r;
    strobe_s = 1'b0;
    done_s   = 1'b0;
    if (!clken) begin
      state_s = state_r;
    end else if (abort) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            mode_s   = sweep_mode_e'(mode);
            origin_s = start_inc;
            target_s = stop_inc;
            step_s   = step_inc;
            dwell_s  = dwell;
            dir_up_s = (stop_inc >= start_inc);
            phi_s    = start_inc;
            cnt_s    = dwell;
            strobe_s = 1'b1;
            state_s  = ST_RUN;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (cnt_r != CNT_ZERO) begin
            cnt_s = cnt_r - CNT_ONE;
          end else if (!at_target_s) begin
            // A zero step leaves the value unchanged, so no strobe.
            phi_s    = nxt_fwd_s;
            cnt_s    = dwell_r;
            strobe_s = (nxt_fwd_s != phi_r);
          end else begin
            done_s = 1'b1;
            case (mode_r)
              SWEEP_REPEAT: begin
                phi_s    = origin_r;
                cnt_s    = dwell_r;
                strobe_s = ~at_origin_s;
              end
              SWEEP_TRI: begin
                origin_s = target_r;
                target_s = origin_r;
                dir_up_s = ~dir_up_r;
                phi_s    = nxt_rev_s;
                cnt_s    = dwell_r;
                strobe_s = ~at_origin_s;
              end
              default: begin
                state_s = ST_IDLE;
              end
            endcase
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
    busy_s = (state_s == ST_RUN);
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath, configuration and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phi_r    <= {APR{1'b0}};
      cnt_r    <= CNT_ZERO;
      mode_r   <= SWEEP_SINGLE;
      origin_r <= {APR{1'b0}};
      target_r <= {APR{1'b0}};
      step_r   <= {APR{1'b0}};
      dwell_r  <= CNT_ZERO;
      dir_up_r <= 1'b1;
      busy_r   <= 1'b0;
      strobe_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      phi_r    <= phi_s;
      cnt_r    <= cnt_s;
      mode_r   <= mode_s;
      origin_r <= origin_s;
      target_r <= target_s;
      step_r   <= step_s;
      dwell_r  <= dwell_s;
      dir_up_r <= dir_up_s;
      busy_r   <= busy_s;
      strobe_r <= strobe_s;
      done_r   <= done_s;
    end
  end

  assign phi_inc_o   = phi_r;
  assign busy        = busy_r;
  assign step_strobe = strobe_r;
  assign sweep_done  = done_r;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb_nco_sweep_ctrl
// Scoreboard bench for nco_sweep_ctrl: stimulus pushes the expected output
// events (value, strobes, busy and enabled-cycle gap since the previous event)
// and a monitor pops and compares whenever step_strobe or sweep_done is seen.
module tb_nco_sweep_ctrl;

  localparam int APR = 20;
  localparam int DW  = 16;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           clken;
  logic           start;
  logic           abort;
  logic [1:0]     mode;
  logic [APR-1:0] start_inc;
  logic [APR-1:0] stop_inc;
  logic [APR-1:0] step_inc;
  logic [DW-1:0]  dwell;
  logic [APR-1:0] phi_inc_o;
  logic           busy;
  logic           step_strobe;
  logic           sweep_done;

  typedef struct {
    logic [APR-1:0] phi;
    logic           strobe;
    logic           done;
    logic           busy;
    int             gap;   // enabled edges since previous event, -1 = don't care
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic en_q = 1'b0;
  int   gap = 0;

  localparam logic [APR-1:0] MAXM3 = 20'd1048573;
  localparam logic [APR-1:0] MAXM1 = 20'd1048575;

  nco_sweep_ctrl #(.APR(APR), .DW(DW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clken       (clken),
    .start       (start),
    .abort       (abort),
    .mode        (mode),
    .start_inc   (start_inc),
    .stop_inc    (stop_inc),
    .step_inc    (step_inc),
    .dwell       (dwell),
    .phi_inc_o   (phi_inc_o),
    .busy        (busy),
    .step_strobe (step_strobe),
    .sweep_done  (sweep_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input logic [APR-1:0] phi, input logic s, input logic d,
                      input logic b, input int g);
    exp_t e;
    e.phi = phi; e.strobe = s; e.done = d; e.busy = b; e.gap = g;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [1:0] m, input logic [APR-1:0] s,
                          input logic [APR-1:0] p, input logic [APR-1:0] st,
                          input logic [DW-1:0] dw);
    @(negedge clk);
    mode = m; start_inc = s; stop_inc = p; step_inc = st; dwell = dw;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string name, input int max_cyc);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < max_cyc) begin
      @(negedge clk); #1;
      i++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Record whether each active edge was enabled
  always @(posedge clk) en_q <= clken;

  // Monitor: compare every strobe/done event against the scoreboard
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (en_q) gap = gap + 1;
      if (step_strobe === 1'b1 || sweep_done === 1'b1) begin
        check("event_on_enabled_edge", en_q, 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got phi=%0d strobe=%0d done=%0d, expected no event",
                   phi_inc_o, step_strobe, sweep_done);
        end else begin
          mon_e = exp_q.pop_front();
          check("ev_phi",    phi_inc_o,   mon_e.phi);
          check("ev_strobe", step_strobe, mon_e.strobe);
          check("ev_done",   sweep_done,  mon_e.done);
          check("ev_busy",   busy,        mon_e.busy);
          if (mon_e.gap >= 0) check("ev_gap", gap, mon_e.gap);
        end
        gap = 0;
      end
    end else begin
      gap = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; clken = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0;
    start_inc = '0; stop_inc = '0; step_inc = '0; dwell = '0;
    cyc(3); #1;
    check("rst_phi",    phi_inc_o,   0);
    check("rst_busy",   busy,        0);
    check("rst_strobe", step_strobe, 0);
    check("rst_done",   sweep_done,  0);
    @(negedge clk); reset_n = 1'b1;
    cyc(2);

    // Up, single, with a start while busy that must be ignored
    push(20'd100, 1'b1, 1'b0, 1'b1, -1);
    push(20'd110, 1'b1, 1'b0, 1'b1, 3);
    push(20'd120, 1'b1, 1'b0, 1'b1, 3);
    push(20'd130, 1'b1, 1'b0, 1'b1, 3);
    push(20'd130, 1'b0, 1'b1, 1'b0, 3);
    do_start(2'd0, 20'd100, 20'd130, 20'd10, 16'd2);
    cyc(3);
    start = 1'b1; mode = 2'd1; start_inc = 20'd500; stop_inc = 20'd600; dwell = 16'd0;
    @(negedge clk); start = 1'b0;
    drain("up_single_drained", 40);
    check("up_single_busy", busy, 0);
    check("up_single_hold", phi_inc_o, 130);

    // Clamp, down, reserved mode behaves as single
    push(20'd130, 1'b1, 1'b0, 1'b1, -1);
    push(20'd118, 1'b1, 1'b0, 1'b1, 1);
    push(20'd106, 1'b1, 1'b0, 1'b1, 1);
    push(20'd100, 1'b1, 1'b0, 1'b1, 1);
    push(20'd100, 1'b0, 1'b1, 1'b0, 1);
    do_start(2'd3, 20'd130, 20'd100, 20'd12, 16'd0);
    drain("clamp_down_drained", 20);
    check("clamp_down_busy", busy, 0);

    // Triangle, then abort together with start
    push(20'd0,  1'b1, 1'b0, 1'b1, -1);
    push(20'd10, 1'b1, 1'b0, 1'b1, 1);
    push(20'd20, 1'b1, 1'b0, 1'b1, 1);
    push(20'd10, 1'b1, 1'b1, 1'b1, 1);
    push(20'd0,  1'b1, 1'b0, 1'b1, 1);
    push(20'd10, 1'b1, 1'b1, 1'b1, 1);
    push(20'd20, 1'b1, 1'b0, 1'b1, 1);
    do_start(2'd2, 20'd0, 20'd20, 20'd10, 16'd0);
    cyc(6);
    abort = 1'b1; start = 1'b1;
    @(negedge clk); abort = 1'b0; start = 1'b0; #1;
    check("tri_abort_busy", busy, 0);
    check("tri_abort_hold", phi_inc_o, 20);
    check("tri_abort_nodone", sweep_done, 0);
    cyc(3);
    check("tri_abort_idle", busy, 0);
    drain("tri_drained", 0);

    // Repeat at the top of the range: clamp, no wrap
    push(MAXM3, 1'b1, 1'b0, 1'b1, -1);
    push(MAXM1, 1'b1, 1'b0, 1'b1, 2);
    push(MAXM3, 1'b1, 1'b1, 1'b1, 2);
    push(MAXM1, 1'b1, 1'b0, 1'b1, 2);
    push(MAXM3, 1'b1, 1'b1, 1'b1, 2);
    do_start(2'd1, MAXM3, MAXM1, 20'd5, 16'd1);
    cyc(8);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0; #1;
    check("rep_abort_busy", busy, 0);
    check("rep_abort_hold", phi_inc_o, MAXM3);
    drain("rep_drained", 0);

    // Start while clken is low is ignored
    @(negedge clk);
    clken = 1'b0; start = 1'b1; mode = 2'd0; start_inc = 20'd7; stop_inc = 20'd9;
    step_inc = 20'd1; dwell = 16'd0;
    @(negedge clk); start = 1'b0; clken = 1'b1;
    cyc(3);
    check("clken0_start_busy", busy, 0);
    check("clken0_start_hold", phi_inc_o, MAXM3);

    // clken toggling: dwell counted in enabled cycles only
    push(20'd50, 1'b1, 1'b0, 1'b1, -1);
    push(20'd60, 1'b1, 1'b0, 1'b1, 2);
    push(20'd60, 1'b0, 1'b1, 1'b0, 2);
    do_start(2'd0, 20'd50, 20'd60, 20'd10, 16'd1);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      clken = ~clken;
      @(negedge clk); #1;
    end
    clken = 1'b1;
    drain("clken_drained", 0);
    check("clken_busy", busy, 0);
    check("clken_hold", phi_inc_o, 60);

    // Asynchronous reset mid-sweep
    push(20'd1000, 1'b1, 1'b0, 1'b1, -1);
    push(20'd1001, 1'b1, 1'b0, 1'b1, 1);
    push(20'd1002, 1'b1, 1'b0, 1'b1, 1);
    do_start(2'd0, 20'd1000, 20'd2000, 20'd1, 16'd0);
    cyc(2);
    #2 reset_n = 1'b0;
    #1;
    check("arst_phi",    phi_inc_o,   0);
    check("arst_busy",   busy,        0);
    check("arst_strobe", step_strobe, 0);
    check("arst_done",   sweep_done,  0);
    drain("arst_drained", 0);
    cyc(2);
    @(negedge clk); reset_n = 1'b1;
    cyc(5); #1;
    check("arst_no_resume_busy", busy, 0);
    check("arst_no_resume_phi",  phi_inc_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
